ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_key_tracker.sv | 169 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key tracker.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_e;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard response/status codes that never represent a key.
    localparam int unsigned N_IGNORED = 7;
    localparam logic [N_IGNORED-1:0][7:0] IGNORED_CODES = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
    };

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_IGNORED; i++) begin
            if (code == IGNORED_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 byte stream into a one-deep key slot with shift/caps case.
// Optional caps-lock tracking is enabled with macro PS2_CAPS_LOCK_EN.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter bit SUPPRESS_REPEAT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_code,
    output logic       letter_case,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);

    ps2_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic [7:0] last_make_q, last_make_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       case_q, case_d;
    logic       overrun_q, overrun_d;

    logic       emit_req;
    logic       emit;
    logic [7:0] emit_code;
    logic       handshake;
    logic       caps;

`ifdef PS2_CAPS_LOCK_EN
    logic caps_q, caps_d;
    assign caps = caps_q;
`else
    assign caps = 1'b0;
`endif

    assign handshake = key_valid_q & key_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        last_make_d = last_make_q;
`ifdef PS2_CAPS_LOCK_EN
        caps_d      = caps_q;
`endif
        emit_req    = 1'b0;
        emit_code   = rx_data;

        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_PAUSE) begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_SKIP;
                    end else if (rx_data == SC_LSHIFT) begin
                        shift_l_d = 1'b1;
                    end else if (rx_data == SC_RSHIFT) begin
                        shift_r_d = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
                    end else if (rx_data == SC_CAPS) begin
                        // Held caps key repeats its make; only the first one toggles.
                        if (last_make_q != SC_CAPS) caps_d = ~caps_q;
                        last_make_d = SC_CAPS;
`endif
                    end else if (!is_ignored(rx_data)) begin
                        emit_req = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rx_data == SC_LSHIFT) shift_l_d = 1'b0;
                    if (rx_data == SC_RSHIFT) shift_r_d = 1'b0;
                    if (rx_data == last_make_q) last_make_d = '0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        if (rx_data == SC_KP_ENTER) begin
                            emit_req  = 1'b1;
                            emit_code = SC_KP_ENTER;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_data == last_make_q) last_make_d = '0;
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        emit = emit_req && !(SUPPRESS_REPEAT && (emit_code == last_make_q));
        if (emit) last_make_d = emit_code;
    end

    always_comb begin
        key_valid_d = key_valid_q;
        scan_code_d = scan_code_q;
        case_d      = case_q;
        overrun_d   = overrun_q;

        if (emit) begin
            if (!key_valid_q || handshake) begin
                key_valid_d = 1'b1;
                scan_code_d = emit_code;
                case_d      = (shift_l_q | shift_r_q) ^ caps;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            last_make_q <= '0;
            key_valid_q <= 1'b0;
            scan_code_q <= '0;
            case_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            last_make_q <= last_make_d;
            key_valid_q <= key_valid_d;
            scan_code_q <= scan_code_d;
            case_q      <= case_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef PS2_CAPS_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) caps_q <= 1'b0;
        else        caps_q <= caps_d;
    end
`endif

    assign key_valid   = key_valid_q;
    assign scan_code   = scan_code_q;
    assign letter_case = case_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker (default and repeat-suppressing instances).
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_ready;

    logic [7:0] scan_code, scan_code_sr;
    logic       letter_case, letter_case_sr;
    logic       key_valid, key_valid_sr;
    logic       overrun, overrun_sr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [8:0] keys[$];
    logic [8:0] keys_sr[$];

    ps2_key_tracker #(.SUPPRESS_REPEAT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .scan_code(scan_code), .letter_case(letter_case), .key_valid(key_valid),
        .key_ready(key_ready), .overrun(overrun)
    );

    ps2_key_tracker #(.SUPPRESS_REPEAT(1'b1)) dut_sr (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .scan_code(scan_code_sr), .letter_case(letter_case_sr), .key_valid(key_valid_sr),
        .key_ready(key_ready), .overrun(overrun_sr)
    );

    always #5 clk = ~clk;

    // Record every completed handshake as {letter_case, scan_code}.
    always @(posedge clk) begin
        if (key_valid && key_ready)       keys.push_back({letter_case, scan_code});
        if (key_valid_sr && key_ready)    keys_sr.push_back({letter_case_sr, scan_code_sr});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] key_at(input int unsigned idx);
        return (idx < keys.size()) ? keys[idx] : 9'h1FF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i]);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        key_ready = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_key_valid",   key_valid,   0);
        check("rst_scan_code",   scan_code,   0);
        check("rst_letter_case", letter_case, 0);
        check("rst_overrun",     overrun,     0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain make/break, including one-cycle latency.
        key_ready = 1'b1;
        keys.delete();
        send_byte(8'h1C);
        check("lat_key_valid", key_valid, 1);
        check("lat_scan_code", scan_code, 8'h1C);
        send_seq('{8'hF0, 8'h1C});
        check("mb_count", keys.size(), 1);
        check("mb_key0",  key_at(0), {1'b0, 8'h1C});

        // Shift gives upper case; releasing shift restores lower case.
        keys.delete();
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C});
        check("sh_count", keys.size(), 2);
        check("sh_key0",  key_at(0), {1'b1, 8'h1C});
        check("sh_key1",  key_at(1), {1'b0, 8'h1C});

        // Overrun: second key dropped, pending key kept.
        key_ready = 1'b0;
        send_byte(8'h16);
        send_byte(8'h1E);
        check("ov_scan_code", scan_code, 8'h16);
        check("ov_key_valid", key_valid, 1);
        check("ov_overrun",   overrun,   1);
        key_ready = 1'b1;
        @(negedge clk);
        check("ov_hs_valid",   key_valid, 0);
        check("ov_hs_overrun", overrun,   0);

        // Emit coinciding with handshake: new key loads, overrun unchanged.
        key_ready = 1'b0;
        send_byte(8'h21);
        send_byte(8'h23);
        check("sim_pend_code", scan_code, 8'h21);
        rx_data   = 8'h22;
        rx_valid  = 1'b1;
        key_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("sim_valid",   key_valid, 1);
        check("sim_code",    scan_code, 8'h22);
        check("sim_overrun", overrun,   1);
        @(negedge clk);
        check("sim_end_valid",   key_valid, 0);
        check("sim_end_overrun", overrun,   0);

        // Pause sequence swallowed, then keypad enter and dropped extended keys.
        keys.delete();
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});
        check("pause_count", keys.size(), 1);
        check("pause_key0",  key_at(0), {1'b0, 8'h29});
        keys.delete();
        send_seq('{8'hE0, 8'h5A});
        check("kpent_count", keys.size(), 1);
        check("kpent_key0",  key_at(0), {1'b0, 8'h5A});
        keys.delete();
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA});
        check("ext_drop_count", keys.size(), 0);

        // Caps lock behaviour depends on build option.
        keys.delete();
        send_seq('{8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12});
`ifdef PS2_CAPS_LOCK_EN
        check("caps_count", keys.size(), 2);
        check("caps_key0",  key_at(0), {1'b1, 8'h1C});
        check("caps_key1",  key_at(1), {1'b0, 8'h1C});
`else
        check("caps_count", keys.size(), 4);
        check("caps_key0",  key_at(0), {1'b0, 8'h58});
        check("caps_key1",  key_at(1), {1'b0, 8'h58});
        check("caps_key2",  key_at(2), {1'b0, 8'h1C});
        check("caps_key3",  key_at(3), {1'b1, 8'h1C});
`endif

        // Reset while in BRK with a key pending discards both.
        key_ready = 1'b0;
        send_byte(8'h2B);
        check("brk_pend_valid", key_valid, 1);
        send_byte(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("brk_rst_valid",   key_valid, 0);
        check("brk_rst_code",    scan_code, 0);
        check("brk_rst_overrun", overrun,   0);
        @(negedge clk);
        rst_n     = 1'b1;
        key_ready = 1'b1;
        keys.delete();
        send_seq('{8'h1C});
        check("brk_rst_count", keys.size(), 1);
        check("brk_rst_key0",  key_at(0), {1'b0, 8'h1C});

        // Repeat suppression: only the first of a run of makes survives.
        pulse_reset();
        keys.delete();
        keys_sr.delete();
        send_seq('{8'h1C, 8'h1C, 8'h1C});
        check("sr_count",     keys_sr.size(), 1);
        check("nosr_count",   keys.size(),    3);
        send_seq('{8'hF0, 8'h1C, 8'h1C});
        check("sr_rearm_count", keys_sr.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
